button_led_sequencer: RTL



---
 rtl/button_led_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/button_led_sequencer.sv
// Push-button responder: two-flop synchronizer, counting debouncer and a
// fill/drain bar-graph sequencer on the 16-bit LED bank, with long-press clear.
module button_led_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    output logic [15:0] led,
    output logic        pressed
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic              sync1, sync2;
    logic [1:0]        sync_valid;
    logic              deb, deb_q;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              armed;
    logic              step, hold_clear;
    logic [15:0]       led_n;
    logic              pressed_n;

    // Input conditioning: synchronizer, debouncer, hold counter, arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_valid <= '0;
            deb        <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt    <= '0;
            hold_cnt   <= '0;
            armed      <= 1'b0;
        end else begin
            sync1      <= button;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            deb_q      <= deb;

            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (!deb) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            // A button still held through reset must be seen released before
            // it can step; sync_valid masks the flops cleared by reset.
            if (sync_valid[1] && !sync2 && !deb) begin
                armed <= 1'b1;
            end
        end
    end

    assign step       = deb && !deb_q && armed;
    assign hold_clear = deb && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        led_n     = led;
        pressed_n = 1'b0;
        if (hold_clear) begin
            led_n   = '0;
            state_n = IDLE;
        end else if (step) begin
            pressed_n = 1'b1;
            unique case (state)
                IDLE: begin
                    led_n   = {led[14:0], 1'b1};
                    state_n = FILL;
                end
                FILL: begin
                    led_n = {led[14:0], 1'b1};
                    if (led_n == 16'hFFFF) begin
                        state_n = FULL;
                    end
                end
                FULL: begin
                    led_n   = {led[14:0], 1'b0};
                    state_n = DRAIN;
                end
                DRAIN: begin
                    led_n = {led[14:0], 1'b0};
                    if (led_n == 16'h0000) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    led_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            led     <= '0;
            pressed <= 1'b0;
        end else begin
            state   <= state_n;
            led     <= led_n;
            pressed <= pressed_n;
        end
    end

endmodule
